pe_mac_acc: RTL and testbench
=============================

Name: pe_mac_acc

Overview:
- Parametrised next-generation systolic processing element for the GEMM array.
- Forwards the A operand east and the B operand south, each with a valid bit and a one-cycle register stage.
- Multiply-accumulates only when both operands are valid.
- Closes a dot-product tile on an in-band "last" marker, moving the result into a double-buffered output register with a valid/ready handshake, so the next tile can begin on the following cycle with no bubble.
- Adds optional saturation, a product counter and a sticky overrun error; the previous PE had none of these.

Parameters:
- DATA_W, 8: operand width, signed two's complement.
- ACC_W, 32: accumulator and result width; must be at least 2*DATA_W.
- CNT_W, 16: width of the per-tile product counter.
- SATURATE, 1: 1 clamps the accumulator at signed ACC_W bounds; 0 wraps modulo 2^ACC_W.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- a_in  in  DATA_W  A operand from the west, signed.
- a_valid_in  in  1  A operand valid.
- a_last_in  in  1  marks the final A of the current dot product.
- b_in  in  DATA_W  B operand from the north, signed.
- b_valid_in  in  1  B operand valid.
- a_out  out  DATA_W  registered A to the east.
- a_valid_out  out  1  registered a_valid_in.
- a_last_out  out  1  registered a_last_in.
- b_out  out  DATA_W  registered B to the south.
- b_valid_out  out  1  registered b_valid_in.
- res_data  out  ACC_W  completed dot product, signed.
- res_count  out  CNT_W  number of products in the completed tile.
- res_sat  out  1  tile saturated (always 0 when SATURATE=0).
- res_valid  out  1  result register full.
- res_ready  in  1  downstream accepts the result.
- err_overrun  out  1  sticky; a tile completed while the result register was blocked.

Behaviour:
- Reset is asynchronous, active-high, and clears every register immediately, including mid-tile: all outputs 0, accumulator 0, count 0, tile-sat 0, err_overrun 0. Partial tiles are discarded.
- Forwarding:
  - a_valid_out, b_valid_out and a_last_out follow their inputs with 1-cycle latency, every cycle.
  - a_out and b_out load only when their own valid is high; otherwise they hold. The a_valid and b_valid streams are independent.
- fire = a_valid_in AND b_valid_in. When fire is low, a_last_in is ignored.
- Arithmetic:
  - Product is signed DATA_W x DATA_W, giving 2*DATA_W bits, sign-extended to ACC_W.
  - sum = acc + product, computed in ACC_W+1 bits.
  - SATURATE=1: on overflow, clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1) and set tile-sat. Later products continue from the clamped value.
  - SATURATE=0: truncate to ACC_W; tile-sat is never set.
- Counter: increments on each fire and saturates at 2^CNT_W-1.
- Accumulator states:
  - IDLE: acc=0, cnt=0. A fire moves to ACCUM, or stays in IDLE if it also carries last.
  - ACCUM: a fire without last updates acc and cnt.
  - Fire with last, from either state: final sum, count+1 and sat form the result. acc, cnt and tile-sat clear to 0 in the same edge, and the state returns to IDLE. A single-product tile (last on the first fire) is legal.
- Output register (EMPTY/FULL):
  - res_valid=1 in FULL. Result fields hold stable while res_valid && !res_ready.
  - Pop: res_valid && res_ready.
  - Completion while EMPTY, or coincident with a pop: load the result, FULL; res_valid rises 1 cycle after the firing edge.
  - Completion while FULL with no pop: new result dropped, register holds the old result, err_overrun set (cleared only by rst). The accumulator still clears.
  - Pop with no completion: EMPTY.
- MAC-to-res_data latency: 1 cycle.

Test Plan:
- Reset: assert rst asynchronously mid-tile after 3 fires -> all outputs 0 without a clk edge; the next tile result excludes the earlier products.
- Basic dot product: A=1,2,3,4 with B=5,6,7,8, last on the 4th, res_ready=1 -> res_data=70, res_count=4, res_sat=0, res_valid pulses for 1 cycle.
- Signed values and gaps: A=-128,127 with B=-128,-1; b_valid low for 2 cycles between the pairs -> res_data=16257, res_count=2. Forwarded a_out holds 127 during the gaps while a_valid_out follows the input stream.
- Saturation: ACC_W=16, SATURATE=1, twelve products of 127*127 -> res_data=32767, res_sat=1. Repeat with SATURATE=0 -> res_data = (12*16129) mod 2^16 as signed, res_sat=0.
- Back-to-back and backpressure: tile X=10 completes, res_ready=0; tile Y=20 completes next -> res_data stays 10, err_overrun=1. Then res_ready=1 coincident with tile Z=30 completing -> res_data=30, res_valid stays 1.
- Single-product tile: fire with last, A=-3 and B=7 -> res_data=-21, res_count=1. A following tile starting on the next cycle is unaffected.

Source files
------------

// File: rtl/pe_mac_acc.sv
// Systolic GEMM processing element: forwards A east and B south.
// It accumulates A*B into a result register that has a valid/ready handshake.
module pe_mac_acc #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 32,
  parameter int CNT_W    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic                     a_valid_in,
  input  logic                     a_last_in,
  input  logic signed [DATA_W-1:0] b_in,
  input  logic                     b_valid_in,
  output logic signed [DATA_W-1:0] a_out,
  output logic                     a_valid_out,
  output logic                     a_last_out,
  output logic signed [DATA_W-1:0] b_out,
  output logic                     b_valid_out,
  output logic signed [ACC_W-1:0]  res_data,
  output logic [CNT_W-1:0]         res_count,
  output logic                     res_sat,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     err_overrun
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  localparam logic signed [ACC_W-1:0] ACC_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};

  logic [0:0]               state;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         cnt;
  logic                     tile_sat;

  logic                     fire;
  logic                     done;
  logic                     pop;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_base;
  logic [CNT_W-1:0]         cnt_base;
  logic signed [ACC_W:0]    sum;
  logic                     ovf;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic [CNT_W-1:0]         cnt_nxt;
  logic                     sat_nxt;

  assign fire = a_valid_in & b_valid_in;
  assign done = fire & a_last_in;
  assign pop  = res_valid & res_ready;

  assign prod     = a_in * b_in;
  assign prod_ext = ACC_W'(prod);

  // IDLE always starts a tile from zero, whatever acc still holds
  assign acc_base = (state == IDLE) ? '0 : acc;
  assign cnt_base = (state == IDLE) ? '0 : cnt;

  assign sum = (ACC_W+1)'(acc_base) + (ACC_W+1)'(prod_ext);
  assign ovf = SATURATE && (sum[ACC_W] != sum[ACC_W-1]);

  always_comb begin
    acc_nxt = sum[ACC_W-1:0];
    if (ovf) begin
      acc_nxt = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  assign cnt_nxt = (&cnt_base) ? cnt_base
                 : cnt_base + CNT_W'(1);
  assign sat_nxt = (tile_sat & (state == ACCUM)) | ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out       <= '0;
      a_valid_out <= 1'b0;
      a_last_out  <= 1'b0;
      b_out       <= '0;
      b_valid_out <= 1'b0;
    end else begin
      a_valid_out <= a_valid_in;
      a_last_out  <= a_last_in;
      b_valid_out <= b_valid_in;
      if (a_valid_in) a_out <= a_in;
      if (b_valid_in) b_out <= b_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      tile_sat <= 1'b0;
    end else if (done) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      tile_sat <= 1'b0;
    end else if (fire) begin
      state    <= ACCUM;
      acc      <= acc_nxt;
      cnt      <= cnt_nxt;
      tile_sat <= sat_nxt;
    end
  end

  // A completion is dropped only when the register is full and not popping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data    <= '0;
      res_count   <= '0;
      res_sat     <= 1'b0;
      res_valid   <= 1'b0;
      err_overrun <= 1'b0;
    end else if (done && (!res_valid || pop)) begin
      res_data  <= acc_nxt;
      res_count <= cnt_nxt;
      res_sat   <= sat_nxt;
      res_valid <= 1'b1;
    end else if (done) begin
      err_overrun <= 1'b1;
    end else if (pop) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_mac_acc.sv
// Scoreboard bench for pe_mac_acc: default, 16-bit saturating and
// 16-bit wrapping instances share one stimulus stream.
module tb_pe_mac_acc;

  logic clk;
  logic rst;
  logic signed [7:0] a_in;
  logic a_valid_in;
  logic a_last_in;
  logic signed [7:0] b_in;
  logic b_valid_in;
  logic res_ready;

  logic signed [7:0] a0_out, b0_out, a1_out, b1_out, a2_out, b2_out;
  logic av0, al0, bv0, av1, al1, bv1, av2, al2, bv2;
  logic signed [31:0] r0_data;
  logic signed [15:0] r1_data, r2_data;
  logic [15:0] r0_cnt, r1_cnt, r2_cnt;
  logic r0_sat, r1_sat, r2_sat;
  logic r0_vld, r1_vld, r2_vld;
  logic e0, e1, e2;

  pe_mac_acc #(.DATA_W(8), .ACC_W(32), .CNT_W(16), .SATURATE(1'b1)) u0 (
    .clk(clk), .rst(rst),
    .a_in(a_in), .a_valid_in(a_valid_in), .a_last_in(a_last_in),
    .b_in(b_in), .b_valid_in(b_valid_in),
    .a_out(a0_out), .a_valid_out(av0), .a_last_out(al0),
    .b_out(b0_out), .b_valid_out(bv0),
    .res_data(r0_data), .res_count(r0_cnt), .res_sat(r0_sat),
    .res_valid(r0_vld), .res_ready(res_ready), .err_overrun(e0));

  pe_mac_acc #(.DATA_W(8), .ACC_W(16), .CNT_W(16), .SATURATE(1'b1)) u1 (
    .clk(clk), .rst(rst),
    .a_in(a_in), .a_valid_in(a_valid_in), .a_last_in(a_last_in),
    .b_in(b_in), .b_valid_in(b_valid_in),
    .a_out(a1_out), .a_valid_out(av1), .a_last_out(al1),
    .b_out(b1_out), .b_valid_out(bv1),
    .res_data(r1_data), .res_count(r1_cnt), .res_sat(r1_sat),
    .res_valid(r1_vld), .res_ready(res_ready), .err_overrun(e1));

  pe_mac_acc #(.DATA_W(8), .ACC_W(16), .CNT_W(16), .SATURATE(1'b0)) u2 (
    .clk(clk), .rst(rst),
    .a_in(a_in), .a_valid_in(a_valid_in), .a_last_in(a_last_in),
    .b_in(b_in), .b_valid_in(b_valid_in),
    .a_out(a2_out), .a_valid_out(av2), .a_last_out(al2),
    .b_out(b2_out), .b_valid_out(bv2),
    .res_data(r2_data), .res_count(r2_cnt), .res_sat(r2_sat),
    .res_valid(r2_vld), .res_ready(res_ready), .err_overrun(e2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint d0, d1, d2;
    bit s0, s1, s2;
    int cnt;
  } exp_t;

  exp_t q[$];
  int prods[$];
  bit m_full, err_exp;
  logic signed [7:0] x_a, x_b;
  logic x_av, x_al, x_bv;
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer sum of a tile, clamped or wrapped per product
  function automatic void tile_model(input int p[$], input int aw, input bit sat,
                                     output longint d, output bit s);
    longint mx, mn, md;
    md = longint'(1) << aw;
    mx = (longint'(1) << (aw - 1)) - 1;
    mn = -(longint'(1) << (aw - 1));
    d = 0;
    s = 1'b0;
    foreach (p[i]) begin
      d += p[i];
      if (sat) begin
        if (d > mx) begin d = mx; s = 1'b1; end
        else if (d < mn) begin d = mn; s = 1'b1; end
      end else begin
        d = d % md;
        if (d > mx) d -= md;
        else if (d < mn) d += md;
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      prods.delete();
      m_full = 1'b0;
      err_exp = 1'b0;
      x_a = '0; x_b = '0; x_av = 1'b0; x_al = 1'b0; x_bv = 1'b0;
    end else begin
      bit pop_m, done;
      exp_t e;
      pop_m = m_full && res_ready;
      done = 1'b0;
      x_av = a_valid_in;
      x_al = a_last_in;
      x_bv = b_valid_in;
      if (a_valid_in) x_a = a_in;
      if (b_valid_in) x_b = b_in;
      if (a_valid_in && b_valid_in) begin
        prods.push_back(int'(a_in) * int'(b_in));
        if (a_last_in) begin
          done = 1'b1;
          tile_model(prods, 32, 1'b1, e.d0, e.s0);
          tile_model(prods, 16, 1'b1, e.d1, e.s1);
          tile_model(prods, 16, 1'b0, e.d2, e.s2);
          e.cnt = prods.size();
          prods.delete();
          if (!m_full || pop_m) begin
            q.push_back(e);
            m_full = 1'b1;
          end else begin
            err_exp = 1'b1;
          end
        end
      end
      if (!done && pop_m) m_full = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      chk("fwd", longint'({a0_out, av0, al0, b0_out, bv0}),
          longint'({x_a, x_av, x_al, x_b, x_bv}));
      chk("res_valid", longint'({r0_vld, r1_vld, r2_vld}),
          longint'({3{m_full}}));
      chk("err_overrun", longint'({e0, e1, e2}), longint'({3{err_exp}}));
      if (r0_vld && res_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = q.pop_front();
          chk("res_data32", longint'(r0_data), e.d0);
          chk("res_count", longint'(r0_cnt), longint'(e.cnt));
          chk("res_sat32", longint'(r0_sat), longint'(e.s0));
          chk("res_data16s", longint'(r1_data), e.d1);
          chk("res_sat16s", longint'(r1_sat), longint'(e.s1));
          chk("res_data16w", longint'(r2_data), e.d2);
          chk("res_sat16w", longint'(r2_sat), longint'(e.s2));
        end
      end
    end
  end

  task automatic step(input int a, input bit av, input bit al,
                      input int b, input bit bv, input bit rr);
    a_in = 8'(a);
    a_valid_in = av;
    a_last_in = al;
    b_in = 8'(b);
    b_valid_in = bv;
    res_ready = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rr);
    step(0, 1'b0, 1'b0, 0, 1'b0, rr);
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, longint'(|{a0_out, av0, al0, b0_out, bv0, r0_data, r0_cnt,
                        r0_sat, r0_vld, e0, r1_data, r1_vld, r2_data,
                        r2_vld, e1, e2}), 0);
  endtask

  initial begin
    rst = 1'b1;
    a_in = '0; a_valid_in = 1'b0; a_last_in = 1'b0;
    b_in = '0; b_valid_in = 1'b0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset_state");
    rst = 1'b0;

    // async reset mid-tile, then a fresh tile must ignore earlier products
    step(5, 1, 0, 6, 1, 1);
    step(7, 1, 0, 3, 1, 1);
    step(-2, 1, 0, 9, 1, 1);
    a_valid_in = 1'b0; b_valid_in = 1'b0; a_last_in = 1'b0;
    #1 rst = 1'b1;
    #1 chk_zero("async_reset");
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    step(1, 1, 1, 1, 1, 1);
    idle(1);

    // basic dot product 1..4 . 5..8
    step(1, 1, 0, 5, 1, 1);
    step(2, 1, 0, 6, 1, 1);
    step(3, 1, 0, 7, 1, 1);
    step(4, 1, 1, 8, 1, 1);
    idle(1); idle(1);

    // signed extremes with B gaps
    step(-128, 1, 0, -128, 1, 1);
    step(127, 1, 0, 0, 0, 1);
    step(127, 1, 0, 0, 0, 1);
    step(127, 1, 1, -1, 1, 1);
    step(5, 0, 0, 9, 0, 1);
    idle(1);

    // twelve 127*127 products
    repeat (11) step(127, 1, 0, 127, 1, 1);
    step(127, 1, 1, 127, 1, 1);
    idle(1); idle(1);

    // single-product tile followed immediately by another tile
    step(-3, 1, 1, 7, 1, 1);
    step(2, 1, 0, 2, 1, 1);
    step(3, 1, 1, 3, 1, 1);
    idle(1); idle(1);

    // backpressure: X held, Y dropped, Z loaded on coincident pop
    step(2, 1, 1, 5, 1, 0);
    idle(0);
    step(4, 1, 1, 5, 1, 0);
    idle(0);
    step(5, 1, 1, 6, 1, 1);
    idle(1); idle(1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(int'($urandom_range(0, 255)),
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 5) == 0,
           int'($urandom_range(0, 255)),
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) < 7);
    end

    repeat (5) idle(1);
    chk("drained", longint'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
